ram_arbiter: RTL and testbench

Arbiter and sequencer for the shared 32x4 single-port RAM. After reset, or on request, it sweeps the whole array to zero. It then shares the single RAM port between two requesters, A and B, using a valid/ready handshake with round-robin priority. Each requester gets its own one-cycle-latency read-response channel.

---
 rtl/ram_arbiter_if.sv | 64 ++++++
 rtl/ram_arbiter.sv | 106 ++++++++++
 tb/tb_ram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundles the sweep control, the two requester command and
//               read-response channels, and the RAM-side port of ram_arbiter.
//               slave  - arbiter view (accepts commands, drives the RAM)
//               master - requester/RAM-model view (drives commands, RAM data)
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 4
);
    // Sweep control
    logic                  clear;
    logic                  busy;

    // Requester A
    logic                  a_valid;
    logic                  a_write;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ready;
    logic                  a_rsp_valid;
    logic [DATA_WIDTH-1:0] a_rsp_data;

    // Requester B
    logic                  b_valid;
    logic                  b_write;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ready;
    logic                  b_rsp_valid;
    logic [DATA_WIDTH-1:0] b_rsp_data;

    // RAM port
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport slave (
        input  clear,
        output busy,
        input  a_valid, a_write, a_addr, a_wdata,
        output a_ready, a_rsp_valid, a_rsp_data,
        input  b_valid, b_write, b_addr, b_wdata,
        output b_ready, b_rsp_valid, b_rsp_data,
        output ram_addr, ram_data_in, ram_write,
        input  ram_data_out
    );

    modport master (
        output clear,
        input  busy,
        output a_valid, a_write, a_addr, a_wdata,
        input  a_ready, a_rsp_valid, a_rsp_data,
        output b_valid, b_write, b_addr, b_wdata,
        input  b_ready, b_rsp_valid, b_rsp_data,
        input  ram_addr, ram_data_in, ram_write,
        output ram_data_out
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Arbiter and sequencer for a shared single-port RAM. After
//               reset (or a clear request while idle) it writes zero to every
//               address, then shares the RAM port between requesters A and B
//               with round-robin priority. Reads return on a per-requester
//               response channel one cycle after acceptance.
// Ports       : clk   - system clock, all state on posedge
//               reset - asynchronous active-high, forces the zero sweep
//               bus   - ram_arbiter_if.slave (clear/busy, A and B command and
//                       response channels, RAM address/data/write port)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    ram_arbiter_if.slave  bus
);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_IDLE = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_prio;      // 0 = A favoured, 1 = B favoured
    logic                  r_a_rsp;
    logic                  r_b_rsp;

    logic                  w_open;
    logic                  w_grant_a;
    logic                  w_grant_b;

    // Arbitration is only open in IDLE with no clear pending; clear wins
    // over any request in the same cycle.
    assign w_open    = (r_state == c_ST_IDLE) && !bus.clear;
    assign w_grant_a = w_open && bus.a_valid && (!bus.b_valid || !r_prio);
    assign w_grant_b = w_open && bus.b_valid && (!bus.a_valid ||  r_prio);

    assign bus.busy    = (r_state == c_ST_INIT);
    assign bus.a_ready = w_grant_a;
    assign bus.b_ready = w_grant_b;

    assign bus.a_rsp_valid = r_a_rsp;
    assign bus.b_rsp_valid = r_b_rsp;
    assign bus.a_rsp_data  = r_a_rsp ? bus.ram_data_out : {DATA_WIDTH{1'b0}};
    assign bus.b_rsp_data  = r_b_rsp ? bus.ram_data_out : {DATA_WIDTH{1'b0}};

    // RAM port: the sweep owns it in INIT, otherwise the granted requester.
    always_comb begin
        bus.ram_write   = 1'b0;
        bus.ram_addr    = '0;
        bus.ram_data_in = '0;
        if (r_state == c_ST_INIT) begin
            bus.ram_write   = 1'b1;
            bus.ram_addr    = r_cnt;
            bus.ram_data_in = {DATA_WIDTH{1'b0}};
        end else if (w_grant_a) begin
            bus.ram_write   = bus.a_write;
            bus.ram_addr    = bus.a_addr;
            bus.ram_data_in = bus.a_wdata;
        end else if (w_grant_b) begin
            bus.ram_write   = bus.b_write;
            bus.ram_addr    = bus.b_addr;
            bus.ram_data_in = bus.b_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
            r_prio  <= 1'b0;
            r_a_rsp <= 1'b0;
            r_b_rsp <= 1'b0;
        end else begin
            // The RAM read data lands one cycle after the address edge, which
            // is exactly when this flag is high.
            r_a_rsp <= w_grant_a && !bus.a_write;
            r_b_rsp <= w_grant_b && !bus.b_write;

            if (w_grant_a) begin
                r_prio <= 1'b1;
            end else if (w_grant_b) begin
                r_prio <= 1'b0;
            end

            if (r_state == c_ST_INIT) begin
                // Counter wraps to zero on the last address, ready for the
                // next sweep.
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                    r_state <= c_ST_IDLE;
                end
            end else if (bus.clear) begin
                r_state <= c_ST_INIT;
                r_cnt   <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with a behavioural RAM,
//               directed scenarios and a randomized run against a reference
//               model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(4)) bus ();

    ram_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port RAM with registered read.
    logic [3:0] ram_mem [32];
    always @(posedge clk) begin
        if (bus.ram_write) ram_mem[bus.ram_addr] <= bus.ram_data_in;
        bus.ram_data_out <= ram_mem[bus.ram_addr];
    end

    task automatic idle_inputs();
        bus.clear   = 1'b0;
        bus.a_valid = 1'b0; bus.a_write = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_valid = 1'b0; bus.b_write = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({bus.busy, bus.a_ready, bus.b_ready, bus.a_rsp_valid, bus.b_rsp_valid, bus.ram_write} !== 6'b100001) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 100001",
                {bus.busy, bus.a_ready, bus.b_ready, bus.a_rsp_valid, bus.b_rsp_valid, bus.ram_write});
        end
        n_checks++;
        if ({bus.ram_addr, bus.ram_data_in, bus.a_rsp_data, bus.b_rsp_data} !== 17'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0",
                {bus.ram_addr, bus.ram_data_in, bus.a_rsp_data, bus.b_rsp_data});
        end
        @(negedge clk); reset = 1'b0; #1;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if ({bus.busy, bus.ram_write, bus.ram_addr, bus.ram_data_in} !== {2'b11, i[4:0], 4'h0}) begin
                n_fail++; $display("FAIL sweep_%0d: got busy/we/addr/data %h expected %h", i,
                    {bus.busy, bus.ram_write, bus.ram_addr, bus.ram_data_in}, {2'b11, i[4:0], 4'h0});
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if ({bus.busy, bus.ram_write} !== 2'b00) begin
            n_fail++; $display("FAIL sweep_done: got busy/we %b expected 00", {bus.busy, bus.ram_write});
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_write = 1'b1; bus.a_addr = 5'd5; bus.a_wdata = 4'hA; #1;
        n_checks++;
        if ({bus.a_ready, bus.b_ready, bus.ram_write, bus.ram_addr, bus.ram_data_in} !== {3'b101, 5'd5, 4'hA}) begin
            n_fail++; $display("FAIL wr_accept: got %h expected %h",
                {bus.a_ready, bus.b_ready, bus.ram_write, bus.ram_addr, bus.ram_data_in}, {3'b101, 5'd5, 4'hA});
        end
        @(negedge clk);
        bus.a_write = 1'b0; #1;
        n_checks++;
        if ({bus.a_ready, bus.ram_write, bus.ram_addr, bus.a_rsp_valid} !== {2'b10, 5'd5, 1'b0}) begin
            n_fail++; $display("FAIL rd_accept: got %h expected %h",
                {bus.a_ready, bus.ram_write, bus.ram_addr, bus.a_rsp_valid}, {2'b10, 5'd5, 1'b0});
        end
        @(negedge clk);
        bus.a_valid = 1'b0; #1;
        n_checks++;
        if ({bus.a_rsp_valid, bus.a_rsp_data, bus.b_rsp_valid} !== {1'b1, 4'hA, 1'b0}) begin
            n_fail++; $display("FAIL rd_rsp: got %h expected %h",
                {bus.a_rsp_valid, bus.a_rsp_data, bus.b_rsp_valid}, {1'b1, 4'hA, 1'b0});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.a_rsp_valid, bus.a_rsp_data} !== 5'd0) begin
            n_fail++; $display("FAIL rd_rsp_once: got %h expected 0", {bus.a_rsp_valid, bus.a_rsp_data});
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        bus.b_valid = 1'b1; bus.b_write = 1'b1; bus.b_addr = 5'd31; bus.b_wdata = 4'h5; #1;
        n_checks++;
        if ({bus.b_ready, bus.ram_write, bus.ram_addr} !== {2'b11, 5'd31}) begin
            n_fail++; $display("FAIL clr_bwrite: got %h expected %h", {bus.b_ready, bus.ram_write, bus.ram_addr}, {2'b11, 5'd31});
        end
        @(negedge clk);
        bus.b_valid = 1'b0; bus.clear = 1'b1;
        bus.a_valid = 1'b1; bus.a_write = 1'b0; bus.a_addr = 5'd31; #1;
        n_checks++;
        if ({bus.busy, bus.a_ready, bus.b_ready, bus.ram_write} !== 4'b0000) begin
            n_fail++; $display("FAIL clr_priority: got %b expected 0000", {bus.busy, bus.a_ready, bus.b_ready, bus.ram_write});
        end
        @(negedge clk);
        bus.a_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.clear = (i == 10);   // clear during the sweep must be ignored
            #1;
            n_checks++;
            if ({bus.busy, bus.ram_write, bus.ram_addr, bus.ram_data_in} !== {2'b11, i[4:0], 4'h0}) begin
                n_fail++; $display("FAIL clr_sweep_%0d: got %h expected %h", i,
                    {bus.busy, bus.ram_write, bus.ram_addr, bus.ram_data_in}, {2'b11, i[4:0], 4'h0});
            end
            @(negedge clk);
        end
        bus.clear = 1'b0;
        bus.a_valid = 1'b1; bus.a_write = 1'b0; bus.a_addr = 5'd31; #1;
        n_checks++;
        if ({bus.busy, bus.a_ready} !== 2'b01) begin
            n_fail++; $display("FAIL clr_done: got busy/a_ready %b expected 01", {bus.busy, bus.a_ready});
        end
        @(negedge clk);
        bus.a_valid = 1'b0; #1;
        n_checks++;
        if ({bus.a_rsp_valid, bus.a_rsp_data} !== 5'b10000) begin
            n_fail++; $display("FAIL clr_readback: got %h expected 10", {bus.a_rsp_valid, bus.a_rsp_data});
        end
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk); reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        #1;
        n_checks++;
        if (bus.ram_addr !== 5'd10) begin
            n_fail++; $display("FAIL mid_sweep_addr: got %0d expected 10", bus.ram_addr);
        end
        reset = 1'b1; #1;
        n_checks++;
        if ({bus.busy, bus.ram_write, bus.ram_addr, bus.ram_data_in} !== {2'b11, 9'd0}) begin
            n_fail++; $display("FAIL mid_sweep_reset: got %h expected %h",
                {bus.busy, bus.ram_write, bus.ram_addr, bus.ram_data_in}, {2'b11, 9'd0});
        end
        @(negedge clk); reset = 1'b0; #1;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if ({bus.busy, bus.ram_addr} !== {1'b1, i[4:0]}) begin
                n_fail++; $display("FAIL restart_%0d: got %h expected %h", i, {bus.busy, bus.ram_addr}, {1'b1, i[4:0]});
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL restart_done: got busy %b expected 0", bus.busy);
        end
    endtask

    // Entered with priority on A (fresh reset).
    task automatic test_round_robin();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.a_valid = (c < 4); bus.a_write = 1'b0; bus.a_addr = 5'd3;
            bus.b_valid = (c < 4); bus.b_write = 1'b0; bus.b_addr = 5'd7;
            #1;
            if (c < 4) begin
                n_checks++;
                if ({bus.a_ready, bus.b_ready, bus.ram_addr} !== ((c % 2 == 0) ? {2'b10, 5'd3} : {2'b01, 5'd7})) begin
                    n_fail++; $display("FAIL rr_grant_%0d: got %h expected %h", c, {bus.a_ready, bus.b_ready, bus.ram_addr},
                        ((c % 2 == 0) ? {2'b10, 5'd3} : {2'b01, 5'd7}));
                end
            end
            if (c > 0) begin
                n_checks++;
                if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.a_rsp_data, bus.b_rsp_data} !== {(c % 2 == 1) ? 2'b10 : 2'b01, 8'h00}) begin
                    n_fail++; $display("FAIL rr_rsp_%0d: got %h expected %h", c,
                        {bus.a_rsp_valid, bus.b_rsp_valid, bus.a_rsp_data, bus.b_rsp_data}, {(c % 2 == 1) ? 2'b10 : 2'b01, 8'h00});
                end
            end
        end
    endtask

    task automatic test_reset_mid_rsp();
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_write = 1'b0; bus.a_addr = 5'd0; #1;
        n_checks++;
        if (bus.a_ready !== 1'b1) begin
            n_fail++; $display("FAIL rsp_rst_accept: got %b expected 1", bus.a_ready);
        end
        @(negedge clk);
        bus.a_valid = 1'b0; #1;
        n_checks++;
        if (bus.a_rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL rsp_rst_pre: got %b expected 1", bus.a_rsp_valid);
        end
        reset = 1'b1; #1;
        n_checks++;
        if ({bus.a_rsp_valid, bus.a_rsp_data, bus.busy} !== 6'b000001) begin
            n_fail++; $display("FAIL rsp_rst_drop: got %b expected 000001", {bus.a_rsp_valid, bus.a_rsp_data, bus.busy});
        end
        @(negedge clk); reset = 1'b0; #1;
        n_checks++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rsp_rst_none: got %b expected 00", {bus.a_rsp_valid, bus.b_rsp_valid});
        end
        for (int k = 0; k < 32; k++) @(negedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rsp_rst_sweep: got busy %b expected 0", bus.busy);
        end
    endtask

    // Random traffic: each requester holds its command until accepted.
    // Entered right after a full sweep with priority on A.
    task automatic test_random();
        logic [3:0] mdl_mem [32];
        logic       next_is_b = 1'b0;   // whoever was not served last
        logic       a_pend = 1'b0, b_pend = 1'b0;
        logic       a_w = 1'b0, b_w = 1'b0;
        logic [4:0] a_ad = '0, b_ad = '0;
        logic [3:0] a_wd = '0, b_wd = '0;
        logic       exp_a_v = 1'b0, exp_b_v = 1'b0;
        logic [3:0] exp_a_d = '0, exp_b_d = '0;
        logic       ga, gb;
        logic [9:0] exp_ram;
        int         a_wait = 0, b_wait = 0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = 4'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1'b1; a_w = 1'($urandom_range(0, 1));
                a_ad = 5'($urandom_range(0, 31)); a_wd = 4'($urandom_range(0, 15));
            end
            if (!b_pend && $urandom_range(0, 2) != 0) begin
                b_pend = 1'b1; b_w = 1'($urandom_range(0, 1));
                b_ad = 5'($urandom_range(0, 31)); b_wd = 4'($urandom_range(0, 15));
            end
            bus.a_valid = a_pend; bus.a_write = a_w; bus.a_addr = a_ad; bus.a_wdata = a_wd;
            bus.b_valid = b_pend; bus.b_write = b_w; bus.b_addr = b_ad; bus.b_wdata = b_wd;
            #1;
            n_checks++;
            if ({bus.a_rsp_valid, bus.a_rsp_data, bus.b_rsp_valid, bus.b_rsp_data} !==
                {exp_a_v, exp_a_v ? exp_a_d : 4'h0, exp_b_v, exp_b_v ? exp_b_d : 4'h0}) begin
                n_fail++; $display("FAIL rnd_rsp_%0d: got %h expected %h", cyc,
                    {bus.a_rsp_valid, bus.a_rsp_data, bus.b_rsp_valid, bus.b_rsp_data},
                    {exp_a_v, exp_a_v ? exp_a_d : 4'h0, exp_b_v, exp_b_v ? exp_b_d : 4'h0});
            end
            if (a_pend && b_pend) begin
                ga = !next_is_b; gb = next_is_b;
            end else begin
                ga = a_pend; gb = b_pend;
            end
            n_checks++;
            if ({bus.a_ready, bus.b_ready} !== {ga, gb}) begin
                n_fail++; $display("FAIL rnd_ready_%0d: got %b expected %b", cyc, {bus.a_ready, bus.b_ready}, {ga, gb});
            end
            exp_ram = ga ? {a_w, a_ad, a_w ? a_wd : bus.ram_data_in} :
                      gb ? {b_w, b_ad, b_w ? b_wd : bus.ram_data_in} : 10'd0;
            n_checks++;
            if ({bus.ram_write, bus.ram_addr, (bus.ram_write || !(ga || gb)) ? bus.ram_data_in : exp_ram[3:0]} !== exp_ram) begin
                n_fail++; $display("FAIL rnd_ram_%0d: got %h expected %h", cyc,
                    {bus.ram_write, bus.ram_addr, bus.ram_data_in}, exp_ram);
            end
            exp_a_v = ga && !a_w; exp_a_d = mdl_mem[a_ad];
            exp_b_v = gb && !b_w; exp_b_d = mdl_mem[b_ad];
            if (ga && a_w) mdl_mem[a_ad] = a_wd;
            if (gb && b_w) mdl_mem[b_ad] = b_wd;
            if (ga) next_is_b = 1'b1;
            if (gb) next_is_b = 1'b0;
            a_wait = (a_pend && !ga) ? a_wait + 1 : 0;
            b_wait = (b_pend && !gb) ? b_wait + 1 : 0;
            n_checks++;
            if (a_wait > 1 || b_wait > 1) begin
                n_fail++; $display("FAIL rnd_starve_%0d: got waits %0d/%0d expected at most 1", cyc, a_wait, b_wait);
            end
            if (ga) a_pend = 1'b0;
            if (gb) b_pend = 1'b0;
        end
        @(negedge clk);
        idle_inputs(); #1;
        n_checks++;
        if ({bus.a_rsp_valid, bus.a_rsp_data, bus.b_rsp_valid, bus.b_rsp_data} !==
            {exp_a_v, exp_a_v ? exp_a_d : 4'h0, exp_b_v, exp_b_v ? exp_b_d : 4'h0}) begin
            n_fail++; $display("FAIL rnd_rsp_last: got %h expected %h",
                {bus.a_rsp_valid, bus.a_rsp_data, bus.b_rsp_valid, bus.b_rsp_data},
                {exp_a_v, exp_a_v ? exp_a_d : 4'h0, exp_b_v, exp_b_v ? exp_b_d : 4'h0});
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_clear();
        test_reset_mid_sweep();
        test_round_robin();
        test_reset_mid_rsp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
